pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the single-cycle 32-bit adder.
- Performs ADD, SUB, add-with-carry and subtract-with-carry on WIDTH-bit operands. The carry chain is split across STAGES register stages to shorten the critical path.
- Produces carry, signed-overflow, zero and negative flags.
- Sits between the EX-stage operand muxes and any wide-arithmetic consumer (address generation, multi-word arithmetic). Uses a valid/ready handshake so downstream stalls back-pressure cleanly.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages. Each stage resolves SEG = WIDTH/STAGES result bits. STAGES >= 1; STAGES = 1 gives a registered single-cycle adder.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used by ADC/SBC only.
- op  input  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB (for SUB/SBC: 1 = no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

Behaviour:
- Single clock domain; reset is synchronous and active-high on rst. All state is sampled on the rising edge of clk.
- Reset: every stage valid bit, out_valid, sum, cout, ovf, zero and neg are cleared to 0. in_ready is 1 in the cycle after reset.
- Reset mid-operation discards all in-flight beats. No partial result is ever presented.
- Operand conditioning at accept:
  - b_eff = b for ADD/ADC; b_eff = ~b for SUB/SBC.
  - c0 = 0 for ADD; 1 for SUB; cin for ADC; cin for SBC (a + ~b + cin).
- Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of a and b_eff plus the carry registered from stage k-1 (c0 for k=0). It registers:
  - the SEG result bits;
  - the carry out;
  - the still-unprocessed upper operand bits, which travel forward skewed;
  - the already-computed lower result bits;
  - its valid bit.
- Final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero and neg are computed combinationally from the final registered sum and must be consistent with it in the same cycle.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES, provided no stall occurs.
- Throughput: one beat per cycle.
- Handshake:
  - Global advance enable: adv = !out_valid || out_ready. in_ready = adv.
  - A beat transfers in when in_valid && in_ready, and out when out_valid && out_ready.
  - When adv = 0, every stage register, including data, holds its value.
  - When adv = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
  - Bubbles do not collapse. Stall behaviour is purely global.
- out_valid and result outputs are stable while out_valid && !out_ready.
- Simultaneous events:
  - Output pop and input push in the same cycle are both honoured.
  - in_ready must not depend combinationally on in_valid.
- Width arithmetic:
  - All additions are modulo 2^WIDTH.
  - No sign extension of operands.
  - cin is ignored for ADD and SUB.
- Operand signals a, b, cin and op are don't-care when in_valid = 0.

Test Plan:
- Defaults (WIDTH=32, STAGES=4), out_ready=1. ADD a=0x0000_0001, b=0xFFFF_FFFF → exactly 4 cycles later: sum=0, cout=1, ovf=0, zero=1, neg=0.
- SUB a=0x8000_0000, b=1 → sum=0x7FFF_FFFF, cout=1, ovf=1, neg=0. Then SUB a=3, b=5 → sum=0xFFFF_FFFE, cout=0, ovf=0, neg=1.
- ADC chain for a 64-bit add:
  - Low beat: ADD 0xFFFF_FFFF + 1, giving sum=0, cout=1.
  - High beat: ADC 0x0000_0001 + 0 with cin=1, giving sum=2.
  - SBC a=5, b=3, cin=0 → sum=1.
- Back-pressure:
  - Stream 8 back-to-back beats with sum values 1..8.
  - Hold out_ready=0 for 3 cycles once the first result is valid → in_ready=0 during the stall, outputs hold value 1.
  - Release → results 1..8 delivered in order with none lost or duplicated.
- Assert rst for one cycle while 3 beats are in flight → next cycle out_valid=0 and all flags are 0. New beats afterwards produce correct results with no stale output.
- Parameter sweep: STAGES=1 (latency 1), WIDTH=8 with STAGES=2 (127+1 → 0x80, ovf=1), WIDTH=64 with STAGES=8.
  - For each configuration, run 10,000 random in_valid/out_ready beats checked against a reference model (a ± b ± carry, flags).

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract with carry-in, split into STAGES carry-chain segments.
// A global advance enable stalls every stage at once, so bubbles never collapse.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int SEG = WIDTH / STAGES;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_e;

  op_e              op_sel;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign op_sel   = op_e'(op);
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    b_eff = b;
    c0    = 1'b0;
    case (op_sel)
      OP_ADD: begin b_eff = b;  c0 = 1'b0; end
      OP_SUB: begin b_eff = ~b; c0 = 1'b1; end
      OP_ADC: begin b_eff = b;  c0 = cin;  end
      OP_SBC: begin b_eff = ~b; c0 = cin;  end
      default: begin b_eff = b; c0 = 1'b0; end
    endcase
  end

  // Each stage narrows: operand registers keep only the bits not yet summed,
  // the result register grows by SEG bits per stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO  = k * SEG;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]    a_in;
    logic [REM-1:0]    b_in;
    logic              c_in;
    logic              v_in;
    logic [SEG:0]      seg_sum;
    logic [LO+SEG-1:0] res_d;
    logic [LO+SEG-1:0] res_q;
    logic              c_q;
    logic              v_q;

    if (k == 0) begin : g_head
      assign a_in  = a;
      assign b_in  = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign res_d = seg_sum[SEG-1:0];
    end else begin : g_body
      assign a_in  = g_stg[k-1].g_fwd.a_q;
      assign b_in  = g_stg[k-1].g_fwd.b_q;
      assign c_in  = g_stg[k-1].c_q;
      assign v_in  = g_stg[k-1].v_q;
      assign res_d = {seg_sum[SEG-1:0], g_stg[k-1].res_q};
    end

    assign seg_sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        res_q <= '0;
      end else if (adv) begin
        v_q   <= v_in;
        c_q   <= seg_sum[SEG];
        res_q <= res_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM-1:SEG];
          b_q <= b_in[REM-1:SEG];
        end
      end
    end else begin : g_tail
      logic ovf_d;
      logic ovf_q;

      // Carry into the MSB is recovered as a^b^sum at that bit.
      assign ovf_d = a_in[SEG-1] ^ b_in[SEG-1] ^ seg_sum[SEG-1] ^ seg_sum[SEG];

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (adv) begin
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].res_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_tail.ovf_q;
  // Gated by out_valid so the cleared (all-zero) post-reset sum does not raise zero.
  assign zero      = out_valid && (sum == '0);
  assign neg       = sum[WIDTH-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed scenarios plus randomized traffic on four
// parameter configurations, checked against a plain-arithmetic reference model.
module tb_pipelined_addsub;

  localparam int NDUT = 4;
  localparam int CW [NDUT] = '{32, 32, 8, 64};
  localparam int CS [NDUT] = '{4, 1, 2, 8};

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] ADC = 2'b10;
  localparam logic [1:0] SBC = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] a_v [NDUT];
  logic [63:0] b_v [NDUT];
  logic [63:0] sum_v [NDUT];
  logic        in_valid_v [NDUT];
  logic        cin_v [NDUT];
  logic [1:0]  op_v [NDUT];
  logic        in_ready_v [NDUT];
  logic        out_valid_v [NDUT];
  logic        out_ready_v [NDUT];
  logic        cout_v [NDUT];
  logic        ovf_v [NDUT];
  logic        zero_v [NDUT];
  logic        neg_v [NDUT];

  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = CW[g];
    logic [W-1:0] s_l;

    pipelined_addsub #(.WIDTH(W), .STAGES(CS[g])) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g][W-1:0]),
      .b         (b_v[g][W-1:0]),
      .cin       (cin_v[g]),
      .op        (op_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .sum       (s_l),
      .cout      (cout_v[g]),
      .ovf       (ovf_v[g]),
      .zero      (zero_v[g]),
      .neg       (neg_v[g])
    );

    assign sum_v[g] = 64'(s_l);
  end

  // Reference: plain modular arithmetic; overflow from operand/result signs.
  function automatic logic [67:0] model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                        input logic ci, input logic [1:0] o);
    logic [63:0] m, bb, s;
    logic [64:0] full;
    logic        c, co, ov;
    m    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = o[0] ? (~bv & m) : (bv & m);
    c    = (o == ADD) ? 1'b0 : (o == SUB) ? 1'b1 : ci;
    full = {1'b0, av & m} + {1'b0, bb} + 65'(c);
    s    = full[63:0] & m;
    co   = full[w];
    ov   = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
    return {s, co, ov, s == 64'd0, s[w-1]};
  endfunction

  function automatic logic [63:0] rnd(input int w);
    logic [63:0] m, r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = '1;
      2:       r = 64'd1 << (w - 1);
      default: r = {$urandom, $urandom};
    endcase
    return r & m;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic send(input int i, input logic [63:0] av, input logic [63:0] bv,
                      input logic ci, input logic [1:0] o);
    int n;
    n = 0;
    in_valid_v[i] = 1'b1;
    a_v[i] = av; b_v[i] = bv; cin_v[i] = ci; op_v[i] = o;
    #1;
    while (!in_ready_v[i] && n < 50) begin
      tick(); #1; n++;
    end
    if (!in_ready_v[i]) begin
      total++; bad++;
      $display("FAIL send_timeout dut=%0d: in_ready=%0b required 1", i, in_ready_v[i]);
    end
    tick();
    in_valid_v[i] = 1'b0;
  endtask

  // Wait (bounded) for a result, take it with a one-cycle out_ready pulse.
  task automatic pop(input int i, output logic [63:0] s, output logic [3:0] f, output bit got);
    got = 1'b0; s = '0; f = '0;
    for (int n = 0; n < 50 && !got; n++) begin
      #1;
      if (out_valid_v[i]) begin
        s = sum_v[i];
        f = {cout_v[i], ovf_v[i], zero_v[i], neg_v[i]};
        got = 1'b1;
        out_ready_v[i] = 1'b1;
        tick();
        out_ready_v[i] = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      total++;
      if ({out_valid_v[i], in_ready_v[i], sum_v[i], cout_v[i], ovf_v[i], zero_v[i], neg_v[i]}
          !== {1'b0, 1'b1, 64'd0, 4'b0000}) begin
        bad++;
        $display("FAIL reset dut=%0d: vld=%0b rdy=%0b sum=%h flags=%b required vld=0 rdy=1 sum=0 flags=0000",
                 i, out_valid_v[i], in_ready_v[i], sum_v[i],
                 {cout_v[i], ovf_v[i], zero_v[i], neg_v[i]});
      end
    end
    tick();
  endtask

  // Single beat into an empty pipe: out_valid must rise exactly S edges later.
  task automatic test_latency(input string name, input int i, input int s_n,
                              input logic [63:0] av, input logic [63:0] bv, input logic ci,
                              input logic [1:0] o, input logic [63:0] es, input logic [3:0] ef);
    out_ready_v[i] = 1'b1;
    in_valid_v[i] = 1'b1;
    a_v[i] = av; b_v[i] = bv; cin_v[i] = ci; op_v[i] = o;
    tick();
    in_valid_v[i] = 1'b0;
    for (int c = 1; c <= s_n; c++) begin
      #1;
      total++;
      if (out_valid_v[i] !== (c == s_n)) begin
        bad++;
        $display("FAIL %s_latency edge=%0d: out_valid=%0b required %0b", name, c, out_valid_v[i], c == s_n);
      end
      if (c == s_n) begin
        total++;
        if ({sum_v[i], cout_v[i], ovf_v[i], zero_v[i], neg_v[i]} !== {es, ef}) begin
          bad++;
          $display("FAIL %s_value: sum=%h flags=%b required sum=%h flags=%b", name, sum_v[i],
                   {cout_v[i], ovf_v[i], zero_v[i], neg_v[i]}, es, ef);
        end
      end
      tick();
    end
    out_ready_v[i] = 1'b0;
  endtask

  task automatic test_sub();
    logic [63:0] ta [2], tbv [2], es [2], s;
    logic [3:0]  ef [2], f;
    bit          got;
    ta  = '{64'h8000_0000, 64'd3};
    tbv = '{64'd1, 64'd5};
    es  = '{64'h7FFF_FFFF, 64'hFFFF_FFFE};
    ef  = '{4'b1100, 4'b0001};
    out_ready_v[0] = 1'b0;
    for (int k = 0; k < 2; k++) send(0, ta[k], tbv[k], 1'b1, SUB);
    for (int k = 0; k < 2; k++) begin
      pop(0, s, f, got);
      total++;
      if (!got || s !== es[k] || f !== ef[k]) begin
        bad++;
        $display("FAIL sub_%0d: got=%0b sum=%h flags=%b required sum=%h flags=%b", k, got, s, f, es[k], ef[k]);
      end
    end
  endtask

  task automatic test_carry_chain();
    logic [63:0] ta [3], tbv [3], es [3], s;
    logic        tc [3];
    logic [1:0]  to [3];
    logic [3:0]  ef [3], f;
    bit          got;
    ta  = '{64'hFFFF_FFFF, 64'd1, 64'd5};
    tbv = '{64'd1, 64'd0, 64'd3};
    tc  = '{1'b0, 1'b1, 1'b0};
    to  = '{ADD, ADC, SBC};
    es  = '{64'd0, 64'd2, 64'd1};
    ef  = '{4'b1010, 4'b0000, 4'b1000};
    out_ready_v[0] = 1'b0;
    for (int k = 0; k < 3; k++) send(0, ta[k], tbv[k], tc[k], to[k]);
    for (int k = 0; k < 3; k++) begin
      pop(0, s, f, got);
      total++;
      if (!got || s !== es[k] || f !== ef[k]) begin
        bad++;
        $display("FAIL carry_chain_%0d: got=%0b sum=%h flags=%b required sum=%h flags=%b", k, got, s, f, es[k], ef[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int sent, nxt, stall;
    bit seen, extra;
    sent = 0; nxt = 1; stall = 0; seen = 1'b0; extra = 1'b0;
    for (int cyc = 0; cyc < 100 && nxt <= 8; cyc++) begin
      if (!seen && out_valid_v[0]) begin
        seen = 1'b1;
        stall = 3;
      end
      out_ready_v[0] = (stall == 0);
      in_valid_v[0] = (sent < 8);
      a_v[0] = 64'(sent + 1); b_v[0] = '0; cin_v[0] = 1'b0; op_v[0] = ADD;
      #1;
      if (stall > 0) begin
        total++;
        if (in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1 || sum_v[0] !== 64'd1) begin
          bad++;
          $display("FAIL b2b_stall: in_ready=%0b out_valid=%0b sum=%h required 0 1 1",
                   in_ready_v[0], out_valid_v[0], sum_v[0]);
        end
        stall--;
      end else if (out_valid_v[0]) begin
        total++;
        if (sum_v[0] !== 64'(nxt)) begin
          bad++;
          $display("FAIL b2b_order: sum=%h required %h", sum_v[0], 64'(nxt));
        end
        nxt++;
      end
      if (in_valid_v[0] && in_ready_v[0]) sent++;
      tick();
    end
    in_valid_v[0] = 1'b0;
    out_ready_v[0] = 1'b1;
    total++;
    if (nxt != 9) begin
      bad++;
      $display("FAIL b2b_count: delivered=%0d required 8", nxt - 1);
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid_v[0]) extra = 1'b1;
      tick();
    end
    total++;
    if (extra) begin
      bad++;
      $display("FAIL b2b_duplicate: extra out_valid=1 required none");
    end
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset_flight();
    logic [63:0] s;
    logic [3:0]  f;
    bit          got, stale;
    stale = 1'b0;
    out_ready_v[0] = 1'b0;
    send(0, 64'd10, 64'd1, 1'b0, ADD);
    send(0, 64'd20, 64'd1, 1'b0, ADD);
    send(0, 64'd30, 64'd1, 1'b0, ADD);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid_v[0], sum_v[0], cout_v[0], ovf_v[0], zero_v[0], neg_v[0]} !== {1'b0, 64'd0, 4'b0000}) begin
      bad++;
      $display("FAIL flight_reset: vld=%0b sum=%h flags=%b required vld=0 sum=0 flags=0000",
               out_valid_v[0], sum_v[0], {cout_v[0], ovf_v[0], zero_v[0], neg_v[0]});
    end
    out_ready_v[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (out_valid_v[0]) stale = 1'b1;
      tick();
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL flight_stale: out_valid=1 after reset required 0");
    end
    out_ready_v[0] = 1'b0;
    send(0, 64'd7, 64'd8, 1'b0, ADD);
    pop(0, s, f, got);
    total++;
    if (!got || s !== 64'd15 || f !== 4'b0000) begin
      bad++;
      $display("FAIL flight_after: got=%0b sum=%h flags=%b required sum=f flags=0000", got, s, f);
    end
  endtask

  task automatic test_random(input int i);
    int          w, acc, cyc;
    logic [67:0] q [$];
    logic [67:0] obs, exp_v, held;
    bit          was_stalled;
    w = CW[i]; acc = 0; cyc = 0; was_stalled = 1'b0; held = '0;
    while (acc < 10000 && cyc < 20000) begin
      in_valid_v[i]  = ($urandom_range(0, 99) < 80);
      out_ready_v[i] = ($urandom_range(0, 99) < 80);
      a_v[i] = rnd(w); b_v[i] = rnd(w);
      cin_v[i] = 1'($urandom_range(0, 1));
      op_v[i]  = 2'($urandom_range(0, 3));
      #1;
      obs = {sum_v[i], cout_v[i], ovf_v[i], zero_v[i], neg_v[i]};
      if (was_stalled) begin
        total++;
        if (!out_valid_v[i] || obs !== held) begin
          bad++;
          $display("FAIL rand_hold dut=%0d: vld=%0b out=%h required vld=1 out=%h", i, out_valid_v[i], obs, held);
        end
      end
      if (out_valid_v[i] && out_ready_v[i]) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rand_spurious dut=%0d: out=%h required no beat", i, obs);
        end else begin
          exp_v = q.pop_front();
          if (obs !== exp_v) begin
            bad++;
            $display("FAIL rand_value dut=%0d: out=%h required %h", i, obs, exp_v);
          end
        end
      end
      was_stalled = out_valid_v[i] && !out_ready_v[i];
      held = obs;
      if (in_valid_v[i] && in_ready_v[i]) begin
        q.push_back(model(w, a_v[i], b_v[i], cin_v[i], op_v[i]));
        acc++;
      end
      tick();
      cyc++;
    end
    in_valid_v[i] = 1'b0;
    out_ready_v[i] = 1'b1;
    for (int c = 0; c < 50 && q.size() > 0; c++) begin
      #1;
      if (out_valid_v[i]) begin
        obs = {sum_v[i], cout_v[i], ovf_v[i], zero_v[i], neg_v[i]};
        exp_v = q.pop_front();
        total++;
        if (obs !== exp_v) begin
          bad++;
          $display("FAIL rand_drain dut=%0d: out=%h required %h", i, obs, exp_v);
        end
      end
      tick();
    end
    total++;
    if (q.size() != 0 || acc < 10000) begin
      bad++;
      $display("FAIL rand_complete dut=%0d: pending=%0d accepted=%0d required pending=0 accepted=10000",
               i, q.size(), acc);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b1;
      a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0; op_v[i] = ADD;
    end
    test_reset();
    test_latency("add_wrap", 0, 4, 64'h0000_0001, 64'hFFFF_FFFF, 1'b1, ADD, 64'd0, 4'b1010);
    test_latency("stages1",  1, 1, 64'd5, 64'd6, 1'b1, SUB, 64'hFFFF_FFFF, 4'b0001);
    test_latency("w8_ovf",   2, 2, 64'd127, 64'd1, 1'b0, ADD, 64'h80, 4'b0101);
    test_latency("w64",      3, 8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, ADC, 64'd0, 4'b1010);
    test_sub();
    test_carry_chain();
    test_back_to_back();
    test_reset_flight();
    for (int i = 0; i < NDUT; i++) test_random(i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
